// File: rtl/obi_model_pkg.sv
// Shared types and helpers for the OBI response model.
//   obi_req_ctl_t : per-channel request control bits seen from the core
//   obi_rsp_ctl_t : per-channel legalised handshake bits returned to the core
//   calc_cw()     : width of a counter that must hold 0..max_pnd
package obi_model_pkg;

    typedef struct packed {
        logic req;
        logic we;
    } obi_req_ctl_t;

    typedef struct packed {
        logic gnt;
        logic rvalid;
    } obi_rsp_ctl_t;

    function automatic int calc_cw(input int max_pnd);
        return $clog2(max_pnd + 1);
    endfunction

endpackage

// File: rtl/obi_rsp_model_if.sv
// Bundle of the core-side OBI signals and the free (random) response
// candidates for all channels. Channel c occupies bit c of the 1-bit
// vectors and slice [c*W +: W] of the wide vectors.
//   slave  : the response model (consumes requests/candidates, drives
//            legalised grant/response and status)
//   master : the environment (core + random source)
// Handshake: a request is accepted in the cycle req_i and gnt_o are both
// high; once req_i is raised it must stay high with stable addr_i/we_i
// until granted. Each accepted request is answered, in order, by exactly
// one cycle with rvalid_o high.
interface obi_rsp_model_if #(
    parameter int NUM_CH = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CW     = 2
);
    logic [NUM_CH-1:0]    req_i;
    logic [NUM_CH-1:0]    we_i;
    logic [NUM_CH*AW-1:0] addr_i;
    logic [NUM_CH-1:0]    rand_gnt_i;
    logic [NUM_CH-1:0]    rand_rvalid_i;
    logic [NUM_CH*DW-1:0] rand_rdata_i;
    logic [NUM_CH-1:0]    gnt_o;
    logic [NUM_CH-1:0]    rvalid_o;
    logic [NUM_CH*DW-1:0] rdata_o;
    logic [NUM_CH*CW-1:0] pnd_cnt_o;
    logic [NUM_CH-1:0]    full_o;
    logic [NUM_CH-1:0]    viol_o;

    modport slave (
        input  req_i, we_i, addr_i, rand_gnt_i, rand_rvalid_i, rand_rdata_i,
        output gnt_o, rvalid_o, rdata_o, pnd_cnt_o, full_o, viol_o
    );

    modport master (
        output req_i, we_i, addr_i, rand_gnt_i, rand_rvalid_i, rand_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, pnd_cnt_o, full_o, viol_o
    );
endinterface

// File: rtl/obi_rsp_chan.sv
// One OBI channel of the response model.
// Legalises free grant/response candidates so the core only ever sees a
// protocol-correct slave: grants are withheld while MAX_PND transactions
// are outstanding, responses only appear for outstanding transactions and
// come back in order. Read responses carry the free data, write responses
// carry zero. Also watches the core side for a request being withdrawn or
// changed while stalled and latches that as a sticky violation.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   req, we, addr           : core request
//   rand_gnt, rand_rvalid,
//   rand_rdata              : free candidates
//   gnt, rvalid, rdata      : legalised handshake/data to core
//   pnd_cnt, full, viol     : outstanding count, count==MAX_PND, sticky violation
module obi_rsp_chan
    import obi_model_pkg::*;
#(
    parameter int MAX_PND = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    localparam int CW     = calc_cw(MAX_PND)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          rand_gnt,
    input  logic          rand_rvalid,
    input  logic [DW-1:0] rand_rdata,
    output logic          gnt,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] pnd_cnt,
    output logic          full,
    output logic          viol
);

    localparam int PW = (MAX_PND > 1) ? $clog2(MAX_PND) : 1;

    obi_req_ctl_t         req_ctl;
    obi_rsp_ctl_t         rsp;

    logic [CW-1:0]        pnd_cnt_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [MAX_PND-1:0]   fifo_q;
    logic                 head_we;
    logic                 full_int;

    logic                 stall_q;
    logic [AW-1:0]        addr_q;
    logic                 we_q;
    logic                 viol_q;

    // Pointers wrap at MAX_PND explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_PND - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_ctl.req = req;
    assign req_ctl.we  = we;

    assign full_int = (pnd_cnt_q == CW'(MAX_PND));

    // Outputs are forced low while reset is asserted, independent of the
    // registered count that is only cleared at the edge.
    assign rsp.gnt    = !reset && req_ctl.req && rand_gnt && !full_int;
    assign rsp.rvalid = !reset && rand_rvalid && (pnd_cnt_q != '0);

    always_comb begin
        head_we = 1'b0;
        for (int i = 0; i < MAX_PND; i++) begin
            if (rd_ptr_q == PW'(i)) head_we = fifo_q[i];
        end
    end

    assign gnt     = rsp.gnt;
    assign rvalid  = rsp.rvalid;
    assign rdata   = (rsp.rvalid && !head_we) ? rand_rdata : '0;
    assign pnd_cnt = pnd_cnt_q;
    assign full    = !reset && full_int;
    assign viol    = viol_q;

    // Outstanding count and FIFO pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pnd_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            case ({rsp.gnt, rsp.rvalid})
                2'b10:   pnd_cnt_q <= pnd_cnt_q + CW'(1);
                2'b01:   pnd_cnt_q <= pnd_cnt_q - CW'(1);
                default: pnd_cnt_q <= pnd_cnt_q;
            endcase
            if (rsp.gnt)    wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rsp.rvalid) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // FIFO payload (write-enable of each accepted request); no reset needed,
    // entries are only read after being written.
    always_ff @(posedge clock) begin
        for (int i = 0; i < MAX_PND; i++) begin
            if (rsp.gnt && (wr_ptr_q == PW'(i))) fifo_q[i] <= req_ctl.we;
        end
    end

    // Stall tracking: a stalled request must be held unchanged next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            if (stall_q && (!req_ctl.req || (addr != addr_q) || (req_ctl.we != we_q)))
                viol_q <= 1'b1;
            if (req_ctl.req && !rsp.gnt) begin
                stall_q <= 1'b1;
                addr_q  <= addr;
                we_q    <= req_ctl.we;
            end else begin
                stall_q <= 1'b0;
            end
        end
    end

`ifdef FORMAL
    int occ;
    always_comb begin
        if (wr_ptr_q >= rd_ptr_q) occ = int'(wr_ptr_q) - int'(rd_ptr_q);
        else                      occ = int'(wr_ptr_q) + MAX_PND - int'(rd_ptr_q);
        assert (int'(pnd_cnt_q) <= MAX_PND);
        // A full FIFO has its pointers coincide, same as an empty one.
        assert (occ == ((int'(pnd_cnt_q) == MAX_PND) ? 0 : int'(pnd_cnt_q)));
    end
`endif

endmodule

// File: rtl/obi_rsp_model.sv
// Multi-channel OBI slave response model. Wraps NUM_CH independent
// obi_rsp_chan instances; holds no state of its own.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   bus          : obi_rsp_model_if.slave carrying all per-channel
//                  request, candidate, response and status vectors
module obi_rsp_model
    import obi_model_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MAX_PND = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    localparam int CW     = calc_cw(MAX_PND)
) (
    input logic            clock,
    input logic            reset,
    obi_rsp_model_if.slave bus
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        obi_rsp_chan #(
            .MAX_PND (MAX_PND),
            .AW      (AW),
            .DW      (DW)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .req         (bus.req_i[c]),
            .we          (bus.we_i[c]),
            .addr        (bus.addr_i[c*AW +: AW]),
            .rand_gnt    (bus.rand_gnt_i[c]),
            .rand_rvalid (bus.rand_rvalid_i[c]),
            .rand_rdata  (bus.rand_rdata_i[c*DW +: DW]),
            .gnt         (bus.gnt_o[c]),
            .rvalid      (bus.rvalid_o[c]),
            .rdata       (bus.rdata_o[c*DW +: DW]),
            .pnd_cnt     (bus.pnd_cnt_o[c*CW +: CW]),
            .full        (bus.full_o[c]),
            .viol        (bus.viol_o[c])
        );
    end

endmodule

// File: tb/tb_obi_rsp_model.sv
module tb_obi_rsp_model;
    localparam int NUM_CH  = 2;
    localparam int MAX_PND = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int CW      = 2;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [NUM_CH-1:0]    req, we, rgnt, rrv;
    logic [NUM_CH*AW-1:0] addr;
    logic [NUM_CH*DW-1:0] rdata;

    obi_rsp_model_if #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .CW(CW)) bus ();

    assign bus.req_i         = req;
    assign bus.we_i          = we;
    assign bus.addr_i        = addr;
    assign bus.rand_gnt_i    = rgnt;
    assign bus.rand_rvalid_i = rrv;
    assign bus.rand_rdata_i  = rdata;

    obi_rsp_model #(.NUM_CH(NUM_CH), .MAX_PND(MAX_PND), .AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: outstanding transactions as a queue of write flags
    bit          pq     [NUM_CH][$];
    bit          stall  [NUM_CH];
    logic [AW-1:0] saddr [NUM_CH];
    bit          swe    [NUM_CH];
    bit          mviol  [NUM_CH];
    bit          eg     [NUM_CH];
    bit          erv    [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < NUM_CH; c++) begin
            int sz;
            logic [DW-1:0] erd;
            sz     = pq[c].size();
            eg[c]  = !reset && req[c] && rgnt[c] && (sz < MAX_PND);
            erv[c] = !reset && rrv[c] && (sz > 0);
            erd    = '0;
            if (erv[c] && pq[c][0] == 1'b0) erd = rdata[c*DW +: DW];
            chk($sformatf("gnt%0d", c),    bus.gnt_o[c],              eg[c]);
            chk($sformatf("rvalid%0d", c), bus.rvalid_o[c],           erv[c]);
            chk($sformatf("rdata%0d", c),  bus.rdata_o[c*DW +: DW],   erd);
            chk($sformatf("pnd%0d", c),    bus.pnd_cnt_o[c*CW +: CW], sz);
            chk($sformatf("full%0d", c),   bus.full_o[c],             !reset && sz == MAX_PND);
            chk($sformatf("viol%0d", c),   bus.viol_o[c],             mviol[c]);
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                pq[c].delete();
                stall[c] = 0;
                mviol[c] = 0;
            end else begin
                if (stall[c] && (!req[c] || addr[c*AW +: AW] != saddr[c] || we[c] != swe[c]))
                    mviol[c] = 1;
                if (eg[c])  pq[c].push_back(we[c]);
                if (erv[c]) void'(pq[c].pop_front());
                if (req[c] && !eg[c]) begin
                    stall[c] = 1;
                    saddr[c] = addr[c*AW +: AW];
                    swe[c]   = we[c];
                end else begin
                    stall[c] = 0;
                end
            end
        end
    endtask

    // driver: inputs change at negedge; outputs checked 1 time unit later
    task automatic cycle();
        #1;
        model_check();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            stall[c] = 0; mviol[c] = 0; saddr[c] = '0; swe[c] = 0;
        end
        reset = 1'b1;
        req = 2'b11; rgnt = 2'b11; rrv = 2'b11; we = 2'b00;
        addr = '0; rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clock);
        #1;
        chk("rst_gnt",    bus.gnt_o,    2'b00);
        chk("rst_rvalid", bus.rvalid_o, 2'b00);
        chk("rst_rdata",  bus.rdata_o,  64'h0);
        chk("rst_full",   bus.full_o,   2'b00);
        cycle();
        cycle();
        reset = 1'b0; req = 2'b00; rgnt = 2'b00; rrv = 2'b00;
        chk("rst_pnd",  bus.pnd_cnt_o, 4'h0);
        chk("rst_viol", bus.viol_o,    2'b00);

        // grants up to the outstanding limit
        req = 2'b01; rgnt = 2'b01; we = 2'b00; addr[31:0] = 32'h40;
        #1 chk("a1_gnt", bus.gnt_o[0], 1'b1);
        cycle();
        chk("a1_pnd", bus.pnd_cnt_o[1:0], 2'd1);
        chk("a1_full", bus.full_o[0], 1'b0);
        #1 chk("a2_gnt", bus.gnt_o[0], 1'b1);
        cycle();
        chk("a2_pnd", bus.pnd_cnt_o[1:0], 2'd2);
        chk("a2_full", bus.full_o[0], 1'b1);
        #1 chk("a3_gnt", bus.gnt_o[0], 1'b0);
        cycle();
        chk("a3_pnd", bus.pnd_cnt_o[1:0], 2'd2);
        rrv = 2'b01; rdata[31:0] = 32'hA5A5_0001;
        #1 chk("a4_gnt", bus.gnt_o[0], 1'b0);
        chk("a4_rvalid", bus.rvalid_o[0], 1'b1);
        chk("a4_rdata", bus.rdata_o[31:0], 32'hA5A5_0001);
        cycle();
        chk("a4_pnd", bus.pnd_cnt_o[1:0], 2'd1);
        #1 chk("a5_gnt", bus.gnt_o[0], 1'b1);
        chk("a5_rvalid", bus.rvalid_o[0], 1'b1);
        cycle();
        chk("a5_pnd_same", bus.pnd_cnt_o[1:0], 2'd1);
        req = 2'b00; rgnt = 2'b00;
        cycle();
        chk("a6_pnd", bus.pnd_cnt_o[1:0], 2'd0);
        #1 chk("a7_rvalid_empty", bus.rvalid_o[0], 1'b0);
        chk("a7_rdata_empty", bus.rdata_o[31:0], 32'h0);
        cycle();
        chk("a7_viol", bus.viol_o, 2'b00);

        // write then read, then two responses
        rrv = 2'b00; req = 2'b01; rgnt = 2'b01; we = 2'b01; addr[31:0] = 32'h80;
        cycle();
        we = 2'b00; addr[31:0] = 32'h84;
        cycle();
        chk("b_pnd", bus.pnd_cnt_o[1:0], 2'd2);
        req = 2'b00; rgnt = 2'b00; rrv = 2'b01; rdata[31:0] = 32'hDEAD_BEEF;
        #1 chk("b_rvalid_wr", bus.rvalid_o[0], 1'b1);
        chk("b_rdata_wr", bus.rdata_o[31:0], 32'h0);
        cycle();
        #1 chk("b_rdata_rd", bus.rdata_o[31:0], 32'hDEAD_BEEF);
        cycle();
        chk("b_pnd_end", bus.pnd_cnt_o[1:0], 2'd0);

        // simultaneous grant and response keep order
        rrv = 2'b00; req = 2'b01; rgnt = 2'b01; we = 2'b00;
        cycle();
        we = 2'b01; rrv = 2'b01; rdata[31:0] = 32'hCAFE_0001;
        #1 chk("c_gnt", bus.gnt_o[0], 1'b1);
        chk("c_rdata_rd", bus.rdata_o[31:0], 32'hCAFE_0001);
        cycle();
        chk("c_pnd", bus.pnd_cnt_o[1:0], 2'd1);
        req = 2'b00; rgnt = 2'b00;
        #1 chk("c_rvalid_wr", bus.rvalid_o[0], 1'b1);
        chk("c_rdata_wr", bus.rdata_o[31:0], 32'h0);
        cycle();
        chk("c_pnd_end", bus.pnd_cnt_o[1:0], 2'd0);
        rrv = 2'b00;

        // address change while stalled on channel 1
        req = 2'b10; rgnt = 2'b00; we = 2'b00; addr[63:32] = 32'h100;
        cycle();
        addr[63:32] = 32'h104;
        cycle();
        chk("d_viol", bus.viol_o, 2'b10);
        req = 2'b00;
        cycle();
        cycle();
        chk("d_viol_sticky", bus.viol_o, 2'b10);

        // reset with two outstanding
        req = 2'b01; rgnt = 2'b01; we = 2'b00; addr[31:0] = 32'h200;
        cycle();
        cycle();
        chk("e_pnd", bus.pnd_cnt_o[1:0], 2'd2);
        req = 2'b00; rgnt = 2'b00; reset = 1'b1; rrv = 2'b11;
        #1 chk("e_rvalid_rst", bus.rvalid_o, 2'b00);
        cycle();
        reset = 1'b0; rrv = 2'b01;
        chk("e_pnd_rst", bus.pnd_cnt_o[1:0], 2'd0);
        #1 chk("e_rvalid_after", bus.rvalid_o[0], 1'b0);
        chk("e_viol_clr", bus.viol_o, 2'b00);
        cycle();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            req   = 2'($urandom_range(0, 3));
            we    = 2'($urandom_range(0, 3));
            rgnt  = 2'($urandom_range(0, 3));
            rrv   = 2'($urandom_range(0, 3));
            addr  = {32'($urandom_range(0, 1) * 4), 32'($urandom_range(0, 1) * 4)};
            rdata = {$urandom, $urandom};
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
